exotiny_wb_arb: RTL and testbench

Two-master Wishbone arbiter that shares the single ExoTiny memory/peripheral slave port between the FazyRV instruction fetch port (imem) and data port (dmem). It sits between the core and the address decoder that generates `sel_gpio` and the memory selects. It grants one master at a time with fair alternation on contention and holds the grant until the transfer is acknowledged. A watchdog terminates transfers the slave never acknowledges.

---
 rtl/exotiny_wb_arb_pkg.sv | 15 +
 rtl/exotiny_wb_arb_if.sv | 25 ++
 rtl/exotiny_wb_arb.sv | 113 +++++++++++
 tb/tb_exotiny_wb_arb.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exotiny_wb_arb_pkg.sv
// Shared types for the ExoTiny Wishbone arbiter: FSM states and master ids.
package exotiny_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IM = 2'd1,
    GNT_DM = 2'd2
  } arb_state_t;

  typedef enum logic {
    IM = 1'b0,
    DM = 1'b1
  } arb_mst_t;

endpackage

// File: rtl/exotiny_wb_arb_if.sv
// Wishbone classic bus bundle; 'master' drives the request, 'slave' answers it.
interface exotiny_wb_arb_if #(
  parameter int ADRW = 32
) ();

  logic            stb;
  logic            we;
  logic [3:0]      be;
  logic [ADRW-1:0] adr;
  logic [31:0]     wdat;
  logic [31:0]     rdat;
  logic            ack;
  logic            err;

  modport master (
    output stb, we, be, adr, wdat,
    input  rdat, ack, err
  );

  modport slave (
    input  stb, we, be, adr, wdat,
    output rdat, ack, err
  );

endinterface

// File: rtl/exotiny_wb_arb.sv
// Two-master Wishbone arbiter (imem fetch / dmem) in front of the single ExoTiny
// slave port: alternating grant on contention, grant held until ack, watchdog abort.
module exotiny_wb_arb
  import exotiny_pkg::*;
#(
  parameter int ADRW    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  exotiny_wb_arb_if.slave   im,
  exotiny_wb_arb_if.slave   dm,
  exotiny_wb_arb_if.master  s
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WD_LAST = (TIMEOUT < 1) ? '0 : CW'(TIMEOUT - 1);

  arb_state_t      r_state;
  arb_state_t      w_state_next;
  arb_mst_t        r_last;
  logic [CW-1:0]   r_wd_cnt;

  logic            w_gstb;
  logic            w_expire;
  logic            w_s_stb;
  logic            w_s_we;
  logic [3:0]      w_s_be;
  logic [ADRW-1:0] w_s_adr;
  logic [31:0]     w_s_wdat;
  logic            w_im_ack;
  logic            w_dm_ack;
  logic            w_im_err;
  logic            w_dm_err;

  // imem is read-only and the slave never reports err; these inputs are intentionally dropped
  logic            w_unused;
  assign w_unused = ^{im.we, im.be, im.wdat, s.err};

  always_comb begin
    w_gstb   = 1'b0;
    if (r_state == GNT_IM) w_gstb = im.stb;
    if (r_state == GNT_DM) w_gstb = dm.stb;
    w_expire = (TIMEOUT != 0) && w_gstb && !s.ack && (r_wd_cnt == WD_LAST);
  end

  always_comb begin
    w_state_next = r_state;
    w_s_stb      = 1'b0;
    w_s_we       = 1'b0;
    w_s_be       = 4'h0;
    w_s_adr      = '0;
    w_s_wdat     = 32'h0;
    w_im_ack     = 1'b0;
    w_dm_ack     = 1'b0;
    w_im_err     = 1'b0;
    w_dm_err     = 1'b0;
    case (r_state)
      IDLE: begin
        // on a tie the master that did not go last wins
        if (im.stb && (!dm.stb || r_last == DM)) w_state_next = GNT_IM;
        else if (dm.stb)                           w_state_next = GNT_DM;
      end
      GNT_IM: begin
        w_s_stb  = im.stb && !w_expire;
        w_s_be   = 4'hF;
        w_s_adr  = im.adr;
        w_im_ack = s.ack;
        w_im_err = w_expire;
        if (s.ack || !im.stb || w_expire) w_state_next = IDLE;
      end
      GNT_DM: begin
        w_s_stb  = dm.stb && !w_expire;
        w_s_we   = dm.we;
        w_s_be   = dm.be;
        w_s_adr  = dm.adr;
        w_s_wdat = dm.wdat;
        w_dm_ack = s.ack;
        w_dm_err = w_expire;
        if (s.ack || !dm.stb || w_expire) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_last   <= DM;
      r_wd_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == IDLE && w_state_next == GNT_IM) r_last <= IM;
      if (r_state == IDLE && w_state_next == GNT_DM) r_last <= DM;
      // cleared while idle so every grant starts at zero; saturates instead of wrapping
      if (r_state == IDLE)    r_wd_cnt <= '0;
      else if (!(&r_wd_cnt))  r_wd_cnt <= r_wd_cnt + CW'(1);
    end
  end

  assign s.stb   = w_s_stb;
  assign s.we    = w_s_we;
  assign s.be    = w_s_be;
  assign s.adr   = w_s_adr;
  assign s.wdat  = w_s_wdat;
  assign im.ack  = w_im_ack;
  assign dm.ack  = w_dm_ack;
  assign im.err  = w_im_err;
  assign dm.err  = w_dm_err;
  assign im.rdat = s.rdat;
  assign dm.rdat = s.rdat;

endmodule

// File: tb/tb_exotiny_wb_arb.sv
// Self-checking bench for exotiny_wb_arb: vector table plus hand sequences, with a
// scoreboard of expected slave-side requests popped when each grant appears.
module tb_exotiny_wb_arb;

  logic clk;
  logic rst;

  exotiny_wb_arb_if #(.ADRW(32)) im_bus ();
  exotiny_wb_arb_if #(.ADRW(32)) dm_bus ();
  exotiny_wb_arb_if #(.ADRW(32)) s_bus ();

  exotiny_wb_arb #(.ADRW(32), .TIMEOUT(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .im    (im_bus),
    .dm    (dm_bus),
    .s     (s_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        dm;
    logic [31:0] adr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdat;
  } exp_t;

  typedef struct {
    logic        im_stb;
    logic        dm_stb;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] im_adr;
    logic [31:0] dm_adr;
    logic [31:0] dm_wdat;
    logic [31:0] rdat;
    int          ack_k;
    logic        exp_dm;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[7];
  int   n_pass;
  int   n_total;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_im(input logic [31:0] adr);
    exp_t e;
    e = '{dm: 1'b0, adr: adr, we: 1'b0, be: 4'hF, wdat: 32'h0};
    sbq.push_back(e);
  endtask

  task automatic push_dm(input logic [31:0] adr, input logic we, input logic [3:0] be,
                         input logic [31:0] wdat);
    exp_t e;
    e = '{dm: 1'b1, adr: adr, we: we, be: be, wdat: wdat};
    sbq.push_back(e);
  endtask

  task automatic pop_grant(output exp_t e);
    e = '{dm: 1'b0, adr: 32'h0, we: 1'b0, be: 4'h0, wdat: 32'h0};
    n_total++;
    if (sbq.size() == 0) begin
      $display("FAIL sb_empty: got grant adr %08h expected no grant", s_bus.adr);
    end else begin
      n_pass++;
      e = sbq.pop_front();
      chk("gnt_adr", s_bus.adr, e.adr);
      chk("gnt_we", s_bus.we, e.we);
      chk("gnt_be", s_bus.be, e.be);
      chk("gnt_wdat", s_bus.wdat, e.wdat);
    end
  endtask

  // Called in the cycle before the grant; slave acks on grant cycle ack_k (0-based).
  task automatic serve(input int ack_k, input logic [31:0] rdat);
    exp_t e;
    e = '{dm: 1'b0, adr: 32'h0, we: 1'b0, be: 4'h0, wdat: 32'h0};
    for (int k = 0; k <= ack_k; k++) begin
      step();
      s_bus.ack  = (k == ack_k);
      s_bus.rdat = rdat;
      #2;
      chk("gnt_stb", s_bus.stb, 1'b1);
      if (k == 0) pop_grant(e);
      chk("im_ack", im_bus.ack, (!e.dm && k == ack_k));
      chk("dm_ack", dm_bus.ack, (e.dm && k == ack_k));
      chk("im_err", im_bus.err, 1'b0);
      chk("dm_err", dm_bus.err, 1'b0);
    end
    chk("im_rdat", im_bus.rdat, rdat);
    chk("dm_rdat", dm_bus.rdat, rdat);
    $display("xfer %s adr=%08h we=%0b be=%h wdat=%08h rdat=%08h ack_cycle=%0d",
             e.dm ? "DM" : "IM", e.adr, e.we, e.be, e.wdat, rdat, ack_k);
  endtask

  task automatic chk_idle(input string name);
    chk(name, s_bus.stb, 1'b0);
    chk({name, "_acks"}, {im_bus.ack, dm_bus.ack}, 2'b00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL sim_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    n_pass  = 0;
    n_total = 0;
    vecs[0] = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h100, 32'h0, 32'h0, 32'hDEADBEEF, 2, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 4'h3, 32'h0, 32'h2000_0004, 32'h1234_5678, 32'h0, 0, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 4'hF, 32'h104, 32'h200, 32'h0, 32'hCAFEF00D, 1, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 4'h8, 32'h108, 32'h300, 32'hAABBCCDD, 32'h0, 3, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 4'h4, 32'h0, 32'h400, 32'h0, 32'h44, 0, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 4'hF, 32'h10C, 32'h410, 32'h0, 32'h5, 0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 4'h1, 32'h0, 32'h500, 32'h44, 32'h0, 6, 1'b1};

    rst = 1'b1;
    im_bus.stb = 0; im_bus.we = 0; im_bus.be = 0; im_bus.adr = 0; im_bus.wdat = 0;
    dm_bus.stb = 0; dm_bus.we = 0; dm_bus.be = 0; dm_bus.adr = 0; dm_bus.wdat = 0;
    s_bus.ack = 0; s_bus.err = 0; s_bus.rdat = 32'h0BAD_F00D;

    // reset state
    step();
    step();
    #2;
    chk("rst_stb", s_bus.stb, 1'b0);
    chk("rst_we", s_bus.we, 1'b0);
    chk("rst_be", s_bus.be, 4'h0);
    chk("rst_adr", s_bus.adr, 32'h0);
    chk("rst_wdat", s_bus.wdat, 32'h0);
    chk("rst_errs", {im_bus.err, dm_bus.err}, 2'b00);
    chk("rst_rdat", im_bus.rdat, 32'h0BAD_F00D);
    step();
    rst = 1'b0;
    #2;
    chk_idle("rel_idle");

    // simultaneous requests out of reset: imem first, then dmem
    step();
    im_bus.stb = 1; im_bus.adr = 32'h10;
    dm_bus.stb = 1; dm_bus.we = 1; dm_bus.be = 4'h6; dm_bus.adr = 32'h20; dm_bus.wdat = 32'h55AA55AA;
    push_im(32'h10);
    push_dm(32'h20, 1'b1, 4'h6, 32'h55AA55AA);
    #2;
    chk_idle("tie_req");
    serve(1, 32'h1111_1111);
    step();
    im_bus.stb = 0; s_bus.ack = 0;
    #2;
    chk_idle("tie_bubble");
    serve(0, 32'h2222_2222);
    step();
    dm_bus.stb = 0; s_bus.ack = 0;
    #2;
    chk_idle("tie_end");

    // vector table: one transfer each, starting from idle
    for (int i = 0; i < 7; i++) begin
      step();
      im_bus.stb = vecs[i].im_stb; im_bus.adr = vecs[i].im_adr;
      dm_bus.stb = vecs[i].dm_stb; dm_bus.we = vecs[i].dm_we; dm_bus.be = vecs[i].dm_be;
      dm_bus.adr = vecs[i].dm_adr; dm_bus.wdat = vecs[i].dm_wdat;
      s_bus.ack = 0;
      if (vecs[i].exp_dm) push_dm(vecs[i].dm_adr, vecs[i].dm_we, vecs[i].dm_be, vecs[i].dm_wdat);
      else push_im(vecs[i].im_adr);
      #2;
      chk("vec_req_idle", s_bus.stb, 1'b0);
      serve(vecs[i].ack_k, vecs[i].rdat);
      step();
      im_bus.stb = 0; dm_bus.stb = 0; s_bus.ack = 0;
      #2;
      chk_idle("vec_bubble");
    end

    // both masters hold stb continuously: strict alternation with one bubble each
    step();
    im_bus.stb = 1; im_bus.adr = 32'h800;
    dm_bus.stb = 1; dm_bus.we = 0; dm_bus.be = 4'hF; dm_bus.adr = 32'h900; dm_bus.wdat = 32'h0;
    for (int t = 0; t < 3; t++) begin
      push_im(32'h800);
      push_dm(32'h900, 1'b0, 4'hF, 32'h0);
    end
    #2;
    chk("alt_req", s_bus.stb, 1'b0);
    for (int t = 0; t < 6; t++) begin
      serve(t % 3, 32'h1000 + t);
      step();
      s_bus.ack = 0;
      if (t == 5) begin
        im_bus.stb = 0; dm_bus.stb = 0;
      end
      #2;
      chk_idle("alt_bubble");
    end

    // watchdog: GPIO byte write never acked, TIMEOUT = 8
    step();
    dm_bus.stb = 1; dm_bus.we = 1; dm_bus.be = 4'h1; dm_bus.adr = 32'h8000_0000; dm_bus.wdat = 32'h44;
    push_dm(32'h8000_0000, 1'b1, 4'h1, 32'h44);
    #2;
    chk("wd_req", s_bus.stb, 1'b0);
    begin
      exp_t e;
      for (int k = 0; k < 7; k++) begin
        step();
        #2;
        chk("wd_stb", s_bus.stb, 1'b1);
        chk("wd_noerr", dm_bus.err, 1'b0);
        if (k == 0) pop_grant(e);
      end
    end
    step();
    #2;
    chk("wd_err", dm_bus.err, 1'b1);
    chk("wd_stb_low", s_bus.stb, 1'b0);
    chk("wd_im_err", im_bus.err, 1'b0);
    chk("wd_dm_ack", dm_bus.ack, 1'b0);
    $display("xfer DM adr=80000000 watchdog err");
    step();
    #2;
    chk("wd_idle_stb", s_bus.stb, 1'b0);
    chk("wd_err_pulse", dm_bus.err, 1'b0);
    step();
    dm_bus.stb = 0;
    #2;
    chk("wd_drop", s_bus.stb, 1'b0);
    step();
    #2;
    chk_idle("wd_end");

    // late ack while idle must not reach a master
    step();
    s_bus.ack = 1;
    #2;
    chk_idle("late_ack");
    step();
    s_bus.ack = 0;
    #2;
    chk_idle("late_ack_after");
    $display("xfer none late ack ignored");

    // stb dropped mid-grant: back to idle, no ack or err
    step();
    im_bus.stb = 1; im_bus.adr = 32'h600;
    push_im(32'h600);
    #2;
    chk("drop_req", s_bus.stb, 1'b0);
    begin
      exp_t e;
      step();
      #2;
      chk("drop_gnt", s_bus.stb, 1'b1);
      pop_grant(e);
    end
    step();
    im_bus.stb = 0;
    #2;
    chk("drop_stb", s_bus.stb, 1'b0);
    chk("drop_errs", {im_bus.err, dm_bus.err, im_bus.ack}, 3'b000);
    step();
    #2;
    chk_idle("drop_idle");
    $display("xfer IM adr=00000600 aborted by master");

    // asynchronous reset during GNT_DM, then a tie goes to imem
    step();
    dm_bus.stb = 1; dm_bus.we = 1; dm_bus.be = 4'hF; dm_bus.adr = 32'h8000_0010; dm_bus.wdat = 32'h99;
    push_dm(32'h8000_0010, 1'b1, 4'hF, 32'h99);
    #2;
    chk("ar_req", s_bus.stb, 1'b0);
    begin
      exp_t e;
      step();
      #2;
      chk("ar_gnt", s_bus.stb, 1'b1);
      pop_grant(e);
    end
    #1;
    rst = 1'b1;
    #1;
    chk("ar_stb", s_bus.stb, 1'b0);
    chk("ar_we", s_bus.we, 1'b0);
    chk("ar_be", s_bus.be, 4'h0);
    chk("ar_adr", s_bus.adr, 32'h0);
    chk("ar_wdat", s_bus.wdat, 32'h0);
    $display("xfer DM adr=80000010 cut by reset");
    step();
    rst = 1'b0;
    im_bus.stb = 1; im_bus.adr = 32'h700;
    push_im(32'h700);
    #2;
    chk("ar_rel", s_bus.stb, 1'b0);
    serve(1, 32'h77);
    step();
    im_bus.stb = 0; dm_bus.stb = 0; s_bus.ack = 0;
    #2;
    chk_idle("ar_end");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
